// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//   Measures an incoming asynchronous PWM waveform. It reports the period
//   (clk cycles between rising edges) and the high time of that same period.
//   If no rising edge arrives for TIMEOUT_CYCLES it reports a zeroed result
//   and raises stuck. stuck_level records which level the input was stuck at.
//
//   Optional feature macro: PWM_CAPTURE_FILTER_EN
//     When defined, a glitch filter follows the synchronizer. The filtered
//     level changes only after the synchronized input has held its new
//     value for FILTER_LEN consecutive cycles.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset (clears every output)
//   pwm_in       in   asynchronous PWM input
//   period_out   out  [CNT_W] last complete period in clk cycles
//   high_out     out  [CNT_W] high time of that period in clk cycles
//   valid        out  one-cycle strobe when period_out/high_out update
//   stuck        out  high while the input is in timeout
//   stuck_level  out  filtered input level captured at timeout entry
// ---------------------------------------------------------------------------
module pwm_capture #(
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 40000,
   parameter int FILTER_LEN     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             valid,
   output logic             stuck,
   output logic             stuck_level
);

   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

   // --- input synchronizer -------------------------------------------------
   logic r_sync1;
   logic r_sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= pwm_in;
         r_sync2 <= r_sync1;
      end
   end

   // --- optional glitch filter ---------------------------------------------
   logic w_lvl;

`ifdef PWM_CAPTURE_FILTER_EN
   localparam int                FCW       = $clog2(FILTER_LEN + 1);
   localparam logic [FCW-1:0]    FILT_LAST = FCW'(FILTER_LEN - 1);

   logic [FCW-1:0] r_filt_cnt;
   logic           r_filt_lvl;

   // r_filt_cnt counts the cycles the synchronized input has disagreed with
   // the filtered level. Any return to agreement restarts the count, so
   // pulses shorter than FILTER_LEN never reach the output.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_filt_cnt <= '0;
         r_filt_lvl <= 1'b0;
      end else if (r_sync2 == r_filt_lvl) begin
         r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_LAST) begin
         r_filt_lvl <= r_sync2;
         r_filt_cnt <= '0;
      end else begin
         r_filt_cnt <= r_filt_cnt + 1'b1;
      end
   end

   assign w_lvl = r_filt_lvl;
`else
   // The filter length has no effect in this build. It is still referenced
   // here so that it remains a live parameter.
   logic w_unused_filter_len;
   assign w_unused_filter_len = (FILTER_LEN >= 1);
   assign w_lvl               = r_sync2;
`endif

   // --- edge detect and cycle counter --------------------------------------
   logic             r_lvl_d;
   logic             w_rise;
   logic             w_fall;
   logic [CNT_W-1:0] r_cnt;

   assign w_rise = w_lvl & ~r_lvl_d;
   assign w_fall = ~w_lvl & r_lvl_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lvl_d <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_lvl_d <= w_lvl;
         if (w_rise)
            r_cnt <= CNT_W'(1);
         else if (r_cnt != CNT_MAX)
            r_cnt <= r_cnt + 1'b1;
      end
   end

   // --- measurement FSM ----------------------------------------------------
   state_t r_state;
   state_t w_state_nxt;
   logic   w_meas_done;
   logic   w_timeout;
   logic   w_hi_capture;

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_rise) w_state_nxt = S_HIGH;
         S_HIGH: begin
            if (w_timeout)   w_state_nxt = S_IDLE;
            else if (w_fall) w_state_nxt = S_LOW;
         end
         S_LOW: begin
            if (w_rise)         w_state_nxt = S_HIGH;
            else if (w_timeout) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // A rise in the timeout cycle completes the measurement instead of
   // timing out. This is why w_timeout is qualified with ~w_rise.
   always_comb begin
      w_meas_done  = (r_state == S_LOW) && w_rise;
      w_timeout    = (r_state != S_IDLE) && (r_cnt == TIMEOUT_VAL) && !w_rise;
      w_hi_capture = (r_state == S_HIGH) && w_fall;
   end

   // --- result registers ---------------------------------------------------
   logic [CNT_W-1:0] r_hi_lat;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_high;
   logic             r_valid;
   logic             r_stuck;
   logic             r_stuck_level;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi_lat      <= '0;
         r_period      <= '0;
         r_high        <= '0;
         r_valid       <= 1'b0;
         r_stuck       <= 1'b0;
         r_stuck_level <= 1'b0;
      end else begin
         r_valid <= w_meas_done | w_timeout;
         if (w_hi_capture)
            r_hi_lat <= r_cnt;
         if (w_meas_done) begin
            r_period <= r_cnt;
            r_high   <= r_hi_lat;
            r_stuck  <= 1'b0;
         end else if (w_timeout) begin
            r_period      <= '0;
            r_high        <= '0;
            r_stuck       <= 1'b1;
            r_stuck_level <= w_lvl;
         end
      end
   end

   assign period_out  = r_period;
   assign high_out    = r_high;
   assign valid       = r_valid;
   assign stuck       = r_stuck;
   assign stuck_level = r_stuck_level;

endmodule

// File: tb/tb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture
//   Self-checking bench for pwm_capture. The stimulus tasks push the
//   expected results into a queue. A negedge monitor records every valid
//   strobe. Each test then pairs the recorded strobes with the queued
//   expectations.
// ---------------------------------------------------------------------------
module tb_pwm_capture;

   localparam int CNT_W          = 16;
   localparam int TIMEOUT_CYCLES = 40000;
`ifdef PWM_CAPTURE_FILTER_EN
   localparam int PH = 6;
   localparam int PL = 10;
`else
   localparam int PH = 3;
   localparam int PL = 5;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             pwm_in;
   logic [CNT_W-1:0] period_out;
   logic [CNT_W-1:0] high_out;
   logic             valid;
   logic             stuck;
   logic             stuck_level;

   always #5 clk = ~clk;

   pwm_capture #(
      .CNT_W          (CNT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .FILTER_LEN     (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pwm_in      (pwm_in),
      .period_out  (period_out),
      .high_out    (high_out),
      .valid       (valid),
      .stuck       (stuck),
      .stuck_level (stuck_level)
   );

   typedef struct {
      logic [CNT_W-1:0] per;
      logic [CNT_W-1:0] hi;
      logic             stk;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   obs_rd   = 0;

   // Monitor: log each valid strobe together with its cycle stamp.
   int               cyc    = 0;
   int               obs_wr = 0;
   logic [CNT_W-1:0] obs_per [0:63];
   logic [CNT_W-1:0] obs_hi  [0:63];
   logic             obs_stk [0:63];
   int               obs_cyc [0:63];

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (valid === 1'b1 && obs_wr < 64) begin
         obs_per[obs_wr] <= period_out;
         obs_hi[obs_wr]  <= high_out;
         obs_stk[obs_wr] <= stuck;
         obs_cyc[obs_wr] <= cyc;
         obs_wr          <= obs_wr + 1;
      end
   end

   task automatic drive(input logic lvl, input int n);
      for (int i = 0; i < n; i++) begin
         pwm_in = lvl;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_period(input int h, input int l);
      drive(1'b1, h);
      drive(1'b0, l);
   endtask

   task automatic push_exp(input int p, input int h, input logic s);
      exp_t e;
      e.per = CNT_W'(p);
      e.hi  = CNT_W'(h);
      e.stk = s;
      exp_q.push_back(e);
   endtask

   task automatic apply_reset();
      rst    = 1'b1;
      pwm_in = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
      exp_q.delete();
      obs_rd = obs_wr;
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      pwm_in = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (period_out !== '0) $display("FAIL reset_period: got %0d, required 0", period_out);
      else n_pass++;
      n_checks++;
      if (high_out !== '0) $display("FAIL reset_high: got %0d, required 0", high_out);
      else n_pass++;
      n_checks++;
      if (valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", valid);
      else n_pass++;
      n_checks++;
      if (stuck !== 1'b0) $display("FAIL reset_stuck: got %b, required 0", stuck);
      else n_pass++;
      n_checks++;
      if (stuck_level !== 1'b0) $display("FAIL reset_stuck_level: got %b, required 0", stuck_level);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      exp_t e;
      int   prev;
      int   waitc;
      apply_reset();
      for (int p = 0; p < 6; p++) begin
         if (p > 0) push_exp(PH + PL, PH, 1'b0);
         drive_period(PH, PL);
      end
      prev = -1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         waitc = 0;
         while (obs_rd >= obs_wr && waitc < 50) begin
            @(posedge clk);
            #1;
            waitc++;
         end
         n_checks++;
         if (obs_rd >= obs_wr)
            $display("FAIL basic_result: no valid strobe, required period=%0d high=%0d", e.per, e.hi);
         else if ({obs_per[obs_rd], obs_hi[obs_rd], obs_stk[obs_rd]} !== {e.per, e.hi, e.stk})
            $display("FAIL basic_result: got period=%0d high=%0d stuck=%b, required period=%0d high=%0d stuck=%b",
                     obs_per[obs_rd], obs_hi[obs_rd], obs_stk[obs_rd], e.per, e.hi, e.stk);
         else n_pass++;
         if (obs_rd < obs_wr) begin
            if (prev >= 0) begin
               n_checks++;
               if (obs_cyc[obs_rd] - prev !== PH + PL)
                  $display("FAIL basic_strobe_spacing: got %0d cycles, required %0d", obs_cyc[obs_rd] - prev, PH + PL);
               else n_pass++;
            end
            prev = obs_cyc[obs_rd];
            obs_rd++;
         end
      end
      drive(1'b0, 20);
      n_checks++;
      if (obs_wr !== obs_rd) $display("FAIL basic_extra_valid: got %0d extra strobes, required 0", obs_wr - obs_rd);
      else n_pass++;
      n_checks++;
      if (stuck !== 1'b0) $display("FAIL basic_stuck: got %b, required 0", stuck);
      else n_pass++;
   endtask

   task automatic test_long_period();
      exp_t e;
      int   prev;
      int   waitc;
      apply_reset();
      drive_period(14000, 6000);
      push_exp(20000, 14000, 1'b0);
      drive_period(14000, 6000);
      push_exp(20000, 14000, 1'b0);
      drive(1'b1, 10);
      prev = -1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         waitc = 0;
         while (obs_rd >= obs_wr && waitc < 50) begin
            @(posedge clk);
            #1;
            waitc++;
         end
         n_checks++;
         if (obs_rd >= obs_wr)
            $display("FAIL long_result: no valid strobe, required period=%0d high=%0d", e.per, e.hi);
         else if ({obs_per[obs_rd], obs_hi[obs_rd], obs_stk[obs_rd]} !== {e.per, e.hi, e.stk})
            $display("FAIL long_result: got period=%0d high=%0d stuck=%b, required period=%0d high=%0d stuck=%b",
                     obs_per[obs_rd], obs_hi[obs_rd], obs_stk[obs_rd], e.per, e.hi, e.stk);
         else n_pass++;
         if (obs_rd < obs_wr) begin
            if (prev >= 0) begin
               n_checks++;
               if (obs_cyc[obs_rd] - prev !== 20000)
                  $display("FAIL long_strobe_spacing: got %0d cycles, required 20000", obs_cyc[obs_rd] - prev);
               else n_pass++;
            end
            prev = obs_cyc[obs_rd];
            obs_rd++;
         end
      end
      n_checks++;
      if (obs_wr !== obs_rd) $display("FAIL long_extra_valid: got %0d extra strobes, required 0", obs_wr - obs_rd);
      else n_pass++;
   endtask

   task automatic test_timeout();
      exp_t e;
      int   prev;
      int   waitc;
      apply_reset();
      for (int p = 0; p < 3; p++) begin
         if (p > 0) push_exp(PH + PL, PH, 1'b0);
         drive_period(PH, PL);
      end
      push_exp(PH + PL, PH, 1'b0);
      push_exp(0, 0, 1'b1);
      drive(1'b1, TIMEOUT_CYCLES + 20);
      prev = -1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         waitc = 0;
         while (obs_rd >= obs_wr && waitc < 50) begin
            @(posedge clk);
            #1;
            waitc++;
         end
         n_checks++;
         if (obs_rd >= obs_wr)
            $display("FAIL timeout_result: no valid strobe, required period=%0d high=%0d stuck=%b", e.per, e.hi, e.stk);
         else if ({obs_per[obs_rd], obs_hi[obs_rd], obs_stk[obs_rd]} !== {e.per, e.hi, e.stk})
            $display("FAIL timeout_result: got period=%0d high=%0d stuck=%b, required period=%0d high=%0d stuck=%b",
                     obs_per[obs_rd], obs_hi[obs_rd], obs_stk[obs_rd], e.per, e.hi, e.stk);
         else n_pass++;
         if (obs_rd < obs_wr) begin
            if (e.stk === 1'b1 && prev >= 0) begin
               n_checks++;
               if (obs_cyc[obs_rd] - prev !== TIMEOUT_CYCLES)
                  $display("FAIL timeout_delay: got %0d cycles, required %0d", obs_cyc[obs_rd] - prev, TIMEOUT_CYCLES);
               else n_pass++;
            end
            prev = obs_cyc[obs_rd];
            obs_rd++;
         end
      end
      n_checks++;
      if (stuck !== 1'b1) $display("FAIL timeout_stuck: got %b, required 1", stuck);
      else n_pass++;
      n_checks++;
      if (stuck_level !== 1'b1) $display("FAIL timeout_stuck_level: got %b, required 1", stuck_level);
      else n_pass++;
      // Resume: the first rise only re-arms, stuck must persist.
      drive(1'b0, PL);
      drive(1'b1, PH);
      drive(1'b0, 4);
      n_checks++;
      if (stuck !== 1'b1) $display("FAIL resume_stuck_held: got %b, required 1", stuck);
      else n_pass++;
      n_checks++;
      if (obs_wr !== obs_rd) $display("FAIL resume_idle_valid: got %0d strobes, required 0", obs_wr - obs_rd);
      else n_pass++;
      drive(1'b0, PL - 4);
      push_exp(PH + PL, PH, 1'b0);
      drive(1'b1, PH);
      drive(1'b0, PL);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         waitc = 0;
         while (obs_rd >= obs_wr && waitc < 50) begin
            @(posedge clk);
            #1;
            waitc++;
         end
         n_checks++;
         if (obs_rd >= obs_wr)
            $display("FAIL resume_result: no valid strobe, required period=%0d high=%0d", e.per, e.hi);
         else if ({obs_per[obs_rd], obs_hi[obs_rd], obs_stk[obs_rd]} !== {e.per, e.hi, e.stk})
            $display("FAIL resume_result: got period=%0d high=%0d stuck=%b, required period=%0d high=%0d stuck=%b",
                     obs_per[obs_rd], obs_hi[obs_rd], obs_stk[obs_rd], e.per, e.hi, e.stk);
         else n_pass++;
         if (obs_rd < obs_wr) obs_rd++;
      end
      n_checks++;
      if (stuck !== 1'b0) $display("FAIL resume_stuck_cleared: got %b, required 0", stuck);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   waitc;
      apply_reset();
      drive_period(PH, PL);
      push_exp(PH + PL, PH, 1'b0);
      drive_period(PH, PL);
      push_exp(PH + PL, PH, 1'b0);
      drive(1'b1, PH);
      drive(1'b0, PL - 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({period_out, high_out, valid, stuck} !== {{CNT_W{1'b0}}, {CNT_W{1'b0}}, 1'b0, 1'b0})
         $display("FAIL midreset_outputs: got period=%0d high=%0d valid=%b stuck=%b, required all 0",
                  period_out, high_out, valid, stuck);
      else n_pass++;
      rst = 1'b0;
      drive(1'b0, 3);
      drive_period(PH, PL);
      push_exp(PH + PL, PH, 1'b0);
      drive_period(PH, PL);
      push_exp(PH + PL, PH, 1'b0);
      drive_period(PH, PL);
      push_exp(PH + PL, PH, 1'b0);
      drive(1'b1, PH);
      drive(1'b0, 4);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         waitc = 0;
         while (obs_rd >= obs_wr && waitc < 50) begin
            @(posedge clk);
            #1;
            waitc++;
         end
         n_checks++;
         if (obs_rd >= obs_wr)
            $display("FAIL midreset_result: no valid strobe, required period=%0d high=%0d", e.per, e.hi);
         else if ({obs_per[obs_rd], obs_hi[obs_rd], obs_stk[obs_rd]} !== {e.per, e.hi, e.stk})
            $display("FAIL midreset_result: got period=%0d high=%0d stuck=%b, required period=%0d high=%0d stuck=%b",
                     obs_per[obs_rd], obs_hi[obs_rd], obs_stk[obs_rd], e.per, e.hi, e.stk);
         else n_pass++;
         if (obs_rd < obs_wr) obs_rd++;
      end
      n_checks++;
      if (obs_wr !== obs_rd) $display("FAIL midreset_extra_valid: got %0d extra strobes, required 0", obs_wr - obs_rd);
      else n_pass++;
   endtask

   task automatic test_glitch();
      exp_t e;
      int   waitc;
      apply_reset();
      drive_period(10, 10);
      push_exp(20, 10, 1'b0);
      // 10-cycle high split by a 2-cycle low glitch
      drive(1'b1, 4);
      drive(1'b0, 2);
`ifndef PWM_CAPTURE_FILTER_EN
      push_exp(6, 4, 1'b0);
`endif
      drive(1'b1, 4);
      drive(1'b0, 10);
`ifdef PWM_CAPTURE_FILTER_EN
      push_exp(20, 10, 1'b0);
`else
      push_exp(14, 4, 1'b0);
`endif
      drive_period(10, 10);
      push_exp(20, 10, 1'b0);
      drive_period(4, 4);
      push_exp(8, 4, 1'b0);
      drive_period(10, 10);
      push_exp(20, 10, 1'b0);
      drive(1'b1, 10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         waitc = 0;
         while (obs_rd >= obs_wr && waitc < 50) begin
            @(posedge clk);
            #1;
            waitc++;
         end
         n_checks++;
         if (obs_rd >= obs_wr)
            $display("FAIL glitch_result: no valid strobe, required period=%0d high=%0d", e.per, e.hi);
         else if ({obs_per[obs_rd], obs_hi[obs_rd], obs_stk[obs_rd]} !== {e.per, e.hi, e.stk})
            $display("FAIL glitch_result: got period=%0d high=%0d stuck=%b, required period=%0d high=%0d stuck=%b",
                     obs_per[obs_rd], obs_hi[obs_rd], obs_stk[obs_rd], e.per, e.hi, e.stk);
         else n_pass++;
         if (obs_rd < obs_wr) obs_rd++;
      end
      n_checks++;
      if (obs_wr !== obs_rd) $display("FAIL glitch_extra_valid: got %0d extra strobes, required 0", obs_wr - obs_rd);
      else n_pass++;
   endtask

   initial begin
      rst    = 1'b1;
      pwm_in = 1'b0;
      test_reset();
      test_basic();
      test_long_period();
      test_timeout();
      test_reset_mid();
      test_glitch();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
